// File: rtl/shift_rotate_pkg.sv
// Shared op codes, FSM state type and stage-count helper for the iterative shift/rotate unit.
package shift_rotate_pkg;

    localparam logic [2:0] SR_OP_SLL  = 3'd0;
    localparam logic [2:0] SR_OP_SRL  = 3'd1;
    localparam logic [2:0] SR_OP_SRA  = 3'd2;
    localparam logic [2:0] SR_OP_ROTR = 3'd3;
    localparam logic [2:0] SR_OP_ROTL = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } sr_state_t;

    // Number of barrel stages needed to cover shift amounts 0..2W-1.
    function automatic int unsigned nstage(input int unsigned w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/sr_stage.sv
// One combinational barrel stage on the 2W data word; K is its position in the per-cycle chain,
// the absolute stage index is i_base + K and the stage moves data by 2^index when enabled.
module sr_stage #(
    parameter int unsigned W = 32,
    parameter int unsigned K = 0
) (
    input  logic [2*W-1:0] i_data,
    input  logic [7:0]     i_base,
    input  logic           i_en,
    input  logic           i_fill,
    input  logic           i_rot,
    input  logic           i_left,
    output logic [2*W-1:0] o_data
);

    int unsigned    w_dist;
    logic [2*W-1:0] w_right;
    logic [2*W-1:0] w_fill_mask;

    always_comb begin
        w_dist      = 32'd1 << (32'(i_base) + K);
        w_right     = i_data >> w_dist;
        w_fill_mask = ~({(2*W){1'b1}} >> w_dist);
        if (!i_en)
            o_data = i_data;
        else if (i_left)
            o_data = i_data << w_dist;
        else if (i_rot)
            o_data = w_right | (i_data << (2*W - w_dist));
        else
            o_data = w_right | (i_fill ? w_fill_mask : '0);
    end

endmodule

// File: rtl/shift_rotate_iter.sv
// Multi-cycle SLL/SRL/SRA/ROTR/ROTL unit: applies log2(2W) barrel stages, STAGES_PER_CYCLE per clock,
// behind valid/ready handshakes with a fixed latency independent of the shift amount.
module shift_rotate_iter
    import shift_rotate_pkg::*;
#(
    parameter int unsigned W                = 32,
    parameter int unsigned STAGES_PER_CYCLE = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res_high,
    output logic [W-1:0] res_low,
    output logic         err
);

    localparam int unsigned NSTAGE = nstage(W);
    localparam int unsigned LW     = $clog2(W);
    localparam int unsigned SPC    = STAGES_PER_CYCLE;

    sr_state_t r_state, w_state_nxt;

    logic [2*W-1:0]        r_data;
    logic [NSTAGE-1:0]     r_amt;
    logic                  r_left, r_fill, r_rot, r_err;
    logic [7:0]            r_cnt;
    logic [W-1:0]          r_res_high, r_res_low;
    logic                  r_res_err;

    logic [2*W-1:0]        w_ld_data;
    logic [NSTAGE-1:0]     w_ld_amt;
    logic                  w_ld_left, w_ld_fill, w_ld_rot, w_ld_err;
    logic [LW-1:0]         w_rotl_amt;
    logic                  w_unused_b;
    logic [SPC:0][2*W-1:0] w_chain;
    logic [SPC-1:0]        w_en;
    logic                  w_last;

    assign w_unused_b = ^b[W-1:LW+1];
    assign w_rotl_amt = -b[LW-1:0];

    // Rotates load {a,a} and always rotate right; ROTL uses the negated amount mod W.
    always_comb begin
        w_ld_data = '0;
        w_ld_amt  = '0;
        w_ld_left = 1'b0;
        w_ld_fill = 1'b0;
        w_ld_rot  = 1'b0;
        w_ld_err  = 1'b0;
        case (op)
            SR_OP_SLL: begin
                w_ld_data = {{W{1'b0}}, a};
                w_ld_amt  = b[LW:0];
                w_ld_left = 1'b1;
            end
            SR_OP_SRL: begin
                w_ld_data = {a, {W{1'b0}}};
                w_ld_amt  = b[LW:0];
            end
            SR_OP_SRA: begin
                w_ld_data = {a, {W{1'b0}}};
                w_ld_amt  = b[LW:0];
                w_ld_fill = a[W-1];
            end
            SR_OP_ROTR: begin
                w_ld_data = {a, a};
                w_ld_amt  = {1'b0, b[LW-1:0]};
                w_ld_rot  = 1'b1;
            end
            SR_OP_ROTL: begin
                w_ld_data = {a, a};
                w_ld_amt  = {1'b0, w_rotl_amt};
                w_ld_rot  = 1'b1;
            end
            default: w_ld_err = 1'b1;
        endcase
    end

    always_comb begin
        w_en = '0;
        for (int unsigned j = 0; j < SPC; j++)
            for (int unsigned k = 0; k < NSTAGE; k++)
                if (32'(r_cnt) + j == k)
                    w_en[j] = r_amt[k];
    end

    assign w_chain[0] = r_data;

    for (genvar j = 0; j < SPC; j++) begin : g_stage
        sr_stage #(
            .W (W),
            .K (j)
        ) u_stage (
            .i_data (w_chain[j]),
            .i_base (r_cnt),
            .i_en   (w_en[j]),
            .i_fill (r_fill),
            .i_rot  (r_rot),
            .i_left (r_left),
            .o_data (w_chain[j+1])
        );
    end

    assign w_last = (32'(r_cnt) + SPC >= NSTAGE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_amt      <= '0;
            r_left     <= 1'b0;
            r_fill     <= 1'b0;
            r_rot      <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_res_high <= '0;
            r_res_low  <= '0;
            r_res_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && in_valid) begin
                r_data <= w_ld_data;
                r_amt  <= w_ld_amt;
                r_left <= w_ld_left;
                r_fill <= w_ld_fill;
                r_rot  <= w_ld_rot;
                r_err  <= w_ld_err;
                r_cnt  <= '0;
            end
            if (r_state == ST_SHIFT) begin
                r_data <= w_chain[SPC];
                r_cnt  <= r_cnt + 8'(SPC);
                if (w_last) begin
                    r_res_high <= (r_rot || r_err) ? '0 : w_chain[SPC][2*W-1:W];
                    r_res_low  <= r_err ? '0 : w_chain[SPC][W-1:0];
                    r_res_err  <= r_err;
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign res_high  = r_res_high;
    assign res_low   = r_res_low;
    assign err       = r_res_err;

endmodule
